// File: rtl/uart_pkt_pkg.sv
// Shared types and sizing helpers for the UART frame packetizer.
package uart_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } pkt_state_t;

  // Header is SYNC0, SYNC1, sequence number; trailer is the checksum byte.
  localparam int unsigned HDR_BYTES = 3;
  localparam int unsigned TRL_BYTES = 1;

  function automatic int unsigned pkt_len(input int unsigned n_ch,
                                          input int unsigned sample_bytes);
    return HDR_BYTES + n_ch * sample_bytes + TRL_BYTES;
  endfunction

endpackage

// File: rtl/uart_frame_packetizer.sv
// Serialises one multi-channel sample frame into a framed byte packet
// (sync, sync, seq, payload, XOR checksum) paced by the UART tx_ready flag.
module uart_frame_packetizer
  import uart_pkt_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned SAMPLE_BYTES = 2,
  parameter logic [7:0]  SYNC0        = 8'hA5,
  parameter logic [7:0]  SYNC1        = 8'h5A,
  parameter int unsigned ACK_TIMEOUT  = 64
) (
  input  logic                           clk,
  input  logic                           reset_b,
  input  logic                           frame_valid,
  input  logic [N_CH*SAMPLE_BYTES*8-1:0] frame_data,
  output logic                           frame_ready,
  output logic [7:0]                     tx_data,
  output logic                           tx_en,
  input  logic                           tx_ready,
  output logic                           busy,
  output logic [7:0]                     seq_num,
  output logic                           ack_err
);

  localparam int unsigned FRAME_W   = N_CH * SAMPLE_BYTES * 8;
  localparam int unsigned PAY_BYTES = N_CH * SAMPLE_BYTES;
  localparam int unsigned PKT_LEN   = pkt_len(N_CH, SAMPLE_BYTES);
  localparam int unsigned IDX_W     = $clog2(PKT_LEN);
  localparam int unsigned PIDX_W    = (PAY_BYTES > 1) ? $clog2(PAY_BYTES) : 1;
  localparam int unsigned PAY_SLOTS = 1 << PIDX_W;
  localparam int unsigned CNT_W     = $clog2(ACK_TIMEOUT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
  localparam logic [IDX_W-1:0] SEQ_IDX  = IDX_W'(HDR_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  pkt_state_t         state;
  logic [FRAME_W-1:0] frame_q;
  logic [IDX_W-1:0]   idx;
  logic [PIDX_W-1:0]  pidx;
  logic [CNT_W-1:0]   ack_cnt;
  logic [7:0]         csum;
  logic [7:0]         cur_byte;
  logic [7:0]         tx_data_q;
  logic [7:0]         pay_bytes [PAY_SLOTS];
  logic               accept;
  logic               ack_timeout;
  logic               byte_done;

  assign frame_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = frame_valid && frame_ready;
  assign tx_en       = (state == SEND) && tx_ready;
  assign tx_data     = tx_en ? cur_byte : tx_data_q;
  assign ack_timeout = (state == WAIT_ACK) && tx_ready && (ack_cnt == CNT_LAST);
  assign byte_done   = ack_timeout || ((state == WAIT_DONE) && tx_ready);
  assign pidx        = PIDX_W'(idx - IDX_W'(HDR_BYTES));

  // Payload bytes in transmit order: channel 0 first, each sample MSB byte first.
  // Slots past the real payload are padding so the mux index is exactly sized.
  for (genvar g = 0; g < PAY_SLOTS; g++) begin : g_pay
    if (g < PAY_BYTES) begin : g_used
      assign pay_bytes[g] =
        frame_q[((g / SAMPLE_BYTES) * SAMPLE_BYTES + SAMPLE_BYTES - 1 - (g % SAMPLE_BYTES)) * 8 +: 8];
    end else begin : g_pad
      assign pay_bytes[g] = '0;
    end
  end

  // Select the byte for the current packet position.
  always_comb begin
    cur_byte = '0;
    if (idx == IDX_W'(0)) begin
      cur_byte = SYNC0;
    end else if (idx == IDX_W'(1)) begin
      cur_byte = SYNC1;
    end else if (idx == SEQ_IDX) begin
      cur_byte = seq_num;
    end else if (idx == LAST_IDX) begin
      cur_byte = csum;
    end else begin
      cur_byte = pay_bytes[pidx];
    end
  end

  // Packet sequencing: state, byte index and sequence number.
  // WAIT_ACK and WAIT_DONE share the byte-completion path so an ack timeout
  // advances exactly like a normal ready-high exit from WAIT_DONE.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state   <= IDLE;
      idx     <= '0;
      seq_num <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= SEND;
            idx   <= '0;
          end
        end
        SEND: begin
          if (tx_ready) state <= WAIT_ACK;
        end
        WAIT_ACK, WAIT_DONE: begin
          if (byte_done) begin
            if (idx == LAST_IDX) begin
              state   <= IDLE;
              idx     <= '0;
              seq_num <= seq_num + 8'd1;
            end else begin
              state <= SEND;
              idx   <= idx + IDX_W'(1);
            end
          end else if ((state == WAIT_ACK) && !tx_ready) begin
            state <= WAIT_DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Latch the frame on acceptance so later input changes cannot corrupt it.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) frame_q <= '0;
    else if (accept) frame_q <= frame_data;
  end

  // Running checksum over seq and payload bytes as they are issued.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      csum <= '0;
    end else if (accept) begin
      csum <= '0;
    end else if (tx_en && (idx >= SEQ_IDX) && (idx != LAST_IDX)) begin
      csum <= csum ^ cur_byte;
    end
  end

  // Hold the last issued byte on tx_data between strobes.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) tx_data_q <= '0;
    else if (tx_en) tx_data_q <= cur_byte;
  end

  // Count cycles waiting for the transmitter to drop ready after a strobe.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ack_cnt <= '0;
    end else if (tx_en) begin
      ack_cnt <= '0;
    end else if ((state == WAIT_ACK) && tx_ready && !ack_timeout) begin
      ack_cnt <= ack_cnt + CNT_W'(1);
    end
  end

  // Sticky flag for a transmitter that never acknowledged a byte.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) ack_err <= 1'b0;
    else if (ack_timeout) ack_err <= 1'b1;
  end

endmodule

// File: doc/uart_frame_packetizer.md
Name: uart_frame_packetizer

Overview:
- Upstream feeder of the UART transmitter. It accepts one multi-channel acoustic sample frame per handshake and serialises it into a framed byte packet: sync bytes, sequence number, payload, XOR checksum.
- It drives the transmitter's data/enable pair one byte at a time and paces itself on the transmitter's ready flag.
- Everything runs in the 100 MHz system domain. tx_ready arrives already in the clk domain, so no synchroniser is needed.

Parameters:
- N_CH, 4, channels per frame
- SAMPLE_BYTES, 2, bytes per sample (sent MSB byte first)
- SYNC0, 8'hA5, first sync byte
- SYNC1, 8'h5A, second sync byte
- ACK_TIMEOUT, 64, clk cycles to wait for tx_ready to drop after a tx_en pulse

Ports:
- clk  in  1  system clock, 100 MHz
- reset_b  in  1  reset
- frame_valid  in  1  frame_data is valid
- frame_data  in  N_CH*SAMPLE_BYTES*8  channel k occupies bits [(k+1)*SAMPLE_BYTES*8-1 : k*SAMPLE_BYTES*8]
- frame_ready  out  1  block can accept a frame
- tx_data  out  8  byte to the UART transmitter
- tx_en  out  1  one-cycle send strobe to the transmitter
- tx_ready  in  1  transmitter idle / ready to send
- busy  out  1  packet in progress
- seq_num  out  8  sequence number of the next packet
- ack_err  out  1  sticky: transmitter failed to acknowledge a byte

Behaviour:
- Reset (reset_b asynchronous, active-low; clock clk):
  - state IDLE; tx_en=0; tx_data=8'h00; busy=0; seq_num=0; ack_err=0; byte index=0.
  - frame_ready=1 as soon as reset releases.
- Packet:
  - Byte order: SYNC0, SYNC1, seq_num, then payload, then checksum.
  - Payload is ch0..ch(N_CH-1); within each sample, MSB byte first.
  - Checksum = XOR of seq_num and all payload bytes. Sync bytes are excluded.
  - Total length = 4 + N_CH*SAMPLE_BYTES (12 at defaults).
- frame_ready = (state==IDLE).
  - A frame is accepted when frame_valid && frame_ready on a rising clk edge.
  - On acceptance, frame_data is latched into an internal register; later frame_data changes have no effect.
- State machine:
  - IDLE: on accept, go to SEND. busy=1 from the next cycle.
  - SEND:
    - Wait until tx_ready=1.
    - Then assert tx_en=1 for exactly one cycle, with tx_data holding the current byte in that same cycle.
    - Go to WAIT_ACK and clear the timeout counter.
  - WAIT_ACK:
    - tx_ready=0 -> WAIT_DONE.
    - Counter reaches ACK_TIMEOUT -> set ack_err and treat the byte as sent (advance as if coming out of WAIT_DONE).
  - WAIT_DONE:
    - Wait for tx_ready=1.
    - Last byte not yet sent: advance the index and go to SEND.
    - Last byte sent: go to IDLE and increment seq_num.
- Latency and pacing:
  - First tx_en comes at the earliest on the cycle after acceptance.
  - Inter-byte spacing is set entirely by the tx_ready handshake.
- tx_data holds its last value when tx_en=0.
- seq_num wraps 8'hFF -> 8'h00. It increments at the same edge where the block returns to IDLE.
- ack_err is cleared only by reset.
- Back-to-back frames:
  - With frame_valid held high, the next frame is accepted on the first cycle in IDLE.
  - That is one cycle after the checksum byte completes.
  - The new packet carries the incremented seq_num.
- Reset mid-packet: the packet is abandoned immediately and all outputs return to their reset values.
- Checksum is accumulated as bytes are issued; it is not precomputed.
- tx_ready stuck low in SEND waits indefinitely; there is no timeout in that state.

Decomposition:
- Package uart_pkt_pkg holds:
  - the state enum (IDLE, SEND, WAIT_ACK, WAIT_DONE);
  - HDR_BYTES=3 and TRL_BYTES=1;
  - a function computing packet length from N_CH and SAMPLE_BYTES.
- SYNC0 and SYNC1 stay parameters.
- No sub-module. Byte selection is an index-driven mux over the latched frame, kept inside the block.

Test Plan:
- Basic packet:
  - Stimulus: defaults, seq_num=0, frame_data=64'hFFFF_0001_ABCD_1234, transmitter model drops ready 2 cycles after tx_en and raises it 10 cycles later.
  - Expected: bytes A5 5A 00 12 34 AB CD 00 01 FF FF 41; exactly 12 single-cycle tx_en pulses; seq_num=1 afterwards.
- Backpressure:
  - Stimulus: hold tx_ready=0 for 500 cycles after acceptance.
  - Expected: no tx_en, busy=1, frame_ready=0, frame_data changes ignored. On release, the first byte is A5 with the original payload.
- Back-to-back and wrap:
  - Stimulus: 257 frames with frame_valid held high.
  - Expected: seq bytes 00..FF then 00; each acceptance lands one cycle after the previous checksum completes; checksums correct for every packet.
- Ack timeout:
  - Stimulus: tx_ready held at 1 permanently.
  - Expected: each byte advances after 64 cycles; ack_err=1 after the first byte and stays 1; the full 12-byte sequence is still emitted.
- Reset mid-packet:
  - Stimulus: assert reset_b=0 after the 5th byte.
  - Expected: tx_en=0, busy=0, seq_num=0, ack_err=0, frame_ready=1 after release. The next frame starts with A5 5A 00.
- Parameter variant:
  - Stimulus: N_CH=1, SAMPLE_BYTES=3, frame 24'h00C0DE.
  - Expected: bytes A5 5A 00 00 C0 DE 1E.
